multilane_pattern_gen: RTL



---
 rtl/pattern_gen_pkg.sv | 34 +++
 rtl/prbs_lfsr.sv | 41 ++++
 rtl/multilane_pattern_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the multilane pattern generator:
// pattern modes, FSM state encodings, PRBS polynomial taps and lane seeding.
package pattern_gen_pkg;

  typedef enum logic [2:0] {
    MODE_SINGLE   = 3'd0,
    MODE_PERIODIC = 3'd1,
    MODE_CLOCK    = 3'd2,
    MODE_PRBS7    = 3'd3,
    MODE_PRBS15   = 3'd4,
    MODE_PRBS31   = 3'd5,
    MODE_CONST6   = 3'd6,
    MODE_CONST7   = 3'd7
  } mode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int PRBS7_N  = 7;
  localparam int PRBS7_T  = 6;
  localparam int PRBS15_N = 15;
  localparam int PRBS15_T = 14;
  localparam int PRBS31_N = 31;
  localparam int PRBS31_T = 28;

  // Lane k seeds with ~k; callers keep the low N bits, which stay nonzero for k < 64.
  function automatic logic [30:0] prbs_seed(input int unsigned lane);
    logic [31:0] v;
    v = ~32'(lane);
    return v[30:0];
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR advancing WIDTH steps per enabled cycle; word[i] is the i-th new bit.
// Seed is loaded on reset or on a load strobe (start of run).
module prbs_lfsr #(
  parameter int N     = 7,
  parameter int T     = 6,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [N-1:0]     seed,
  output logic [WIDTH-1:0] word
);

  logic [N-1:0] state_q;
  logic [N-1:0] state_next;

  always_comb begin
    logic [N-1:0] s;
    logic         nb;
    s    = state_q;
    nb   = 1'b0;
    word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nb      = s[N-1] ^ s[T-1];
      s       = {s[N-2:0], nb};
      word[i] = nb;
    end
    state_next = s;
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state_q <= seed;
    end else if (adv) begin
      state_q <= state_next;
    end
  end

endmodule

// File: rtl/multilane_pattern_gen.sv
// Multilane stimulus source: pulse, periodic pulse, clock and PRBS patterns with
// single-bit error injection on lane 0. All outputs are registered.
module multilane_pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int   LANES = 1,
  parameter int   WIDTH = 1,
  parameter logic B0    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [2:0]             mode,
  input  logic [15:0]            delay,
  input  logic [15:0]            pulse_len,
  input  logic [15:0]            period,
  input  logic                   inj_err,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   valid,
  output logic                   done
);

  localparam logic [LANES*WIDTH-1:0] IDLE_WORD = {(LANES*WIDTH){B0}};

  logic [1:0]  state_q;
  logic        en_q;
  mode_e       mode_q;
  logic [15:0] delay_q;
  logic [15:0] len_q;
  logic [16:0] per_q;
  logic [31:0] t_q;
  logic [16:0] ph_q;

  logic        start;
  logic        single_end;
  logic        adv;
  logic [16:0] end_ui;
  logic [16:0] eff_period;
  mode_e       start_mode;
  logic [31:0] t_sat;
  logic [16:0] ph_next;
  logic [WIDTH-1:0] pat;
  logic [LANES*WIDTH-1:0] dout_next;

  logic [WIDTH-1:0] p7_w  [LANES];
  logic [WIDTH-1:0] p15_w [LANES];
  logic [WIDTH-1:0] p31_w [LANES];

  // A run needs a fresh 0->1 edge; en_q resets to 1 so a held-high en cannot start one.
  assign start      = (state_q == ST_IDLE) && en && !en_q;
  assign end_ui     = {1'b0, delay_q} + {1'b0, len_q};
  assign single_end = (mode_q == MODE_SINGLE) && (t_q >= 32'(end_ui));
  assign adv        = (state_q == ST_RUN) && en && !single_end;
  assign t_sat      = (t_q > (32'hFFFF_FFFF - 32'(WIDTH))) ? 32'hFFFF_FFFF : t_q + 32'(WIDTH);
  assign start_mode = ((mode == 3'(MODE_PERIODIC)) && (period == 16'd0)) ? MODE_SINGLE : mode_e'(mode);

  always_comb begin
    eff_period = {1'b0, period};
    if (eff_period < 17'(WIDTH)) eff_period = 17'(WIDTH);
    if (eff_period < ({1'b0, pulse_len} + 17'd1)) eff_period = {1'b0, pulse_len} + 17'd1;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [30:0] SEED = prbs_seed(k);

    prbs_lfsr #(.N(PRBS7_N), .T(PRBS7_T), .WIDTH(WIDTH)) u_p7 (
      .clk(clk), .rst(rst), .load(start), .adv(adv && (mode_q == MODE_PRBS7)),
      .seed(SEED[PRBS7_N-1:0]), .word(p7_w[k])
    );
    prbs_lfsr #(.N(PRBS15_N), .T(PRBS15_T), .WIDTH(WIDTH)) u_p15 (
      .clk(clk), .rst(rst), .load(start), .adv(adv && (mode_q == MODE_PRBS15)),
      .seed(SEED[PRBS15_N-1:0]), .word(p15_w[k])
    );
    prbs_lfsr #(.N(PRBS31_N), .T(PRBS31_T), .WIDTH(WIDTH)) u_p31 (
      .clk(clk), .rst(rst), .load(start), .adv(adv && (mode_q == MODE_PRBS31)),
      .seed(SEED[PRBS31_N-1:0]), .word(p31_w[k])
    );
  end

  // Shared pulse/clock word. The periodic phase re-zeroes at the first UI reaching
  // delay and wraps with a single subtraction, which holds because per_q >= WIDTH.
  always_comb begin
    logic [32:0] u;
    logic [16:0] c;
    logic        started;
    logic        on;
    pat     = '0;
    u       = '0;
    on      = 1'b0;
    c       = ph_q;
    started = (t_q >= 32'(delay_q));
    for (int i = 0; i < WIDTH; i++) begin
      u  = {1'b0, t_q} + 33'(i);
      on = 1'b0;
      case (mode_q)
        MODE_SINGLE: on = (u >= 33'(delay_q)) && (u < 33'(end_ui));
        MODE_PERIODIC: begin
          if (u == 33'(delay_q)) begin
            c       = '0;
            started = 1'b1;
          end
          on = started && (c < {1'b0, len_q});
          if (started) begin
            c = c + 17'd1;
            if (c >= per_q) c = c - per_q;
          end
        end
        MODE_CLOCK: on = ~u[0];
        default:    on = 1'b0;
      endcase
      pat[i] = on ^ B0;
    end
    ph_next = started ? c : 17'd0;
  end

  always_comb begin
    logic [WIDTH-1:0] lw;
    dout_next = IDLE_WORD;
    lw        = '0;
    for (int k = 0; k < LANES; k++) begin
      case (mode_q)
        MODE_SINGLE, MODE_PERIODIC, MODE_CLOCK: lw = pat;
        MODE_PRBS7:  lw = p7_w[k];
        MODE_PRBS15: lw = p15_w[k];
        MODE_PRBS31: lw = p31_w[k];
        default:     lw = {WIDTH{B0}};
      endcase
      dout_next[k*WIDTH +: WIDTH] = lw;
    end
    dout_next[0] = dout_next[0] ^ inj_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b1;
      mode_q  <= MODE_SINGLE;
      delay_q <= '0;
      len_q   <= '0;
      per_q   <= '0;
      t_q     <= '0;
      ph_q    <= '0;
      dout    <= IDLE_WORD;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      en_q <= en;
      case (state_q)
        ST_IDLE: begin
          dout  <= IDLE_WORD;
          valid <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            mode_q  <= start_mode;
            delay_q <= delay;
            len_q   <= pulse_len;
            per_q   <= eff_period;
            t_q     <= '0;
            ph_q    <= '0;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_q <= ST_IDLE;
            dout    <= IDLE_WORD;
            valid   <= 1'b0;
            done    <= 1'b0;
          end else if (single_end) begin
            state_q <= ST_DONE;
            dout    <= IDLE_WORD;
            valid   <= 1'b1;
            done    <= 1'b1;
          end else begin
            dout  <= dout_next;
            valid <= 1'b1;
            t_q   <= t_sat;
            ph_q  <= ph_next;
          end
        end
        ST_DONE: begin
          if (!en) begin
            state_q <= ST_IDLE;
            dout    <= IDLE_WORD;
            valid   <= 1'b0;
            done    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
